starter_rx: RTL and testbench

- Receiving end of the starter byte stream (clk, rst, 8-bit data, valid qualifier; no backpressure on the stream).
- Packs incoming bytes little-endian into 32-bit words and buffers them in a first-word-fall-through (FWFT) FIFO.
- Presents words on a ready/valid output port for downstream logic or a scoreboard.
- Counts words dropped on FIFO overflow, since the input side cannot be stalled.

---
 rtl/starter_pkg.sv | 14 +
 rtl/starter_fifo.sv | 59 +++++
 rtl/starter_rx.sv | 96 +++++++++
 tb/tb_starter_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/starter_pkg.sv
// Shared constants and the word record carried through the starter receive path.
package starter_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // One packed word plus the number of valid low-order byte lanes (1..4).
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [2:0]        bytes;
  } starter_word_t;

endpackage

// File: rtl/starter_fifo.sv
// Synchronous first-word-fall-through FIFO holding starter words.
// The head entry is visible on rdata whenever empty=0. rdata is 0 when the FIFO is empty.
// A push while full is ignored unless a pop happens in the same cycle.
module starter_fifo
  import starter_pkg::*;
#(
  parameter int WIDTH = $bits(starter_word_t),
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the slot that the incoming word takes.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array. It has no reset because stale entries are never visible past the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/starter_rx.sv
// Receiving end of the starter byte stream. Incoming bytes are packed little-endian into
// 32-bit words and buffered in a FWFT FIFO. Words that arrive while the FIFO is full are
// dropped, because the byte stream cannot be stalled. Each drop increments a saturating
// counter and sets a sticky flag.
//
// Output handshake: out_valid means out_data/out_bytes hold the oldest buffered word. That
// word is consumed on a rising edge where out_valid && out_ready. Both out_data and out_bytes
// stay stable until then. out_valid never depends combinationally on out_ready.
module starter_rx
  import starter_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [2:0]              out_bytes,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  logic [1:0]        idx;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] lane_word;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  starter_word_t     push_word;
  starter_word_t     head_word;

  // Merge the current byte into its lane so that a completing byte or a coincident flush includes it.
  always_comb begin
    lane_word = acc;
    if (in_valid) lane_word[BYTE_W*idx +: BYTE_W] = in_data;
  end

  assign push_req        = (in_valid && (idx == 2'd3)) || (flush && ((idx != 2'd0) || in_valid));
  assign push_word.data  = lane_word;
  assign push_word.bytes = {1'b0, idx} + {2'b00, in_valid};
  assign pop             = out_valid && out_ready;
  assign drop            = push_req && full && !pop;

  // Packer state. Every push restarts the word, including a push that gets dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 2'd0;
      acc <= '0;
    end else if (push_req) begin
      idx <= 2'd0;
      acc <= '0;
    end else if (in_valid) begin
      idx <= idx + 2'd1;
      acc <= lane_word;
    end
  end

  // Drop accounting. Only rst clears these two.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      overflow <= 1'b1;
    end
  end

  starter_fifo #(
    .WIDTH ($bits(starter_word_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign out_data  = head_word.data;
  assign out_bytes = head_word.bytes;

endmodule

// File: tb/tb_starter_rx.sv
// Bench for starter_rx. It combines a directed vector table, hand-written full/reset
// sequences and a random phase. A behavioural packer and FIFO model feeds an expected-word
// queue, and the bench compares each DUT word against that queue as the word is popped.
module tb_starter_rx;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic [3:0]  level;
  logic        overflow;
  logic [DW-1:0] drop_cnt;

  // clock / reset
  always #5 clk = ~clk;

  starter_rx #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // scoreboard / model state
  logic [34:0] exp_q[$];
  int          m_idx;
  logic [31:0] m_acc;
  int          m_drop;
  logic        m_ovf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_idx  = 0;
    m_acc  = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model to the next edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic f, input logic r);
    logic [31:0] nacc;
    logic        push_m;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #1;
    check("out_valid", out_valid, exp_q.size() > 0);
    check("level", level, exp_q.size());
    check("drop_cnt", drop_cnt, m_drop);
    check("overflow", overflow, m_ovf);
    if (exp_q.size() == 0) check("empty_head", {out_data, out_bytes}, 35'd0);
    if (r && exp_q.size() > 0) begin
      check("word", {out_data, out_bytes}, exp_q[0]);
      void'(exp_q.pop_front());
    end
    nacc = m_acc;
    if (v) nacc[8*m_idx +: 8] = d;
    push_m = (v && m_idx == 3) || (f && (m_idx != 0 || v));
    if (push_m) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({nacc, 3'(m_idx + (v ? 1 : 0))});
      else begin
        if (m_drop < (1 << DW) - 1) m_drop++;
        m_ovf = 1'b1;
      end
      m_idx = 0;
      m_acc = '0;
    end else if (v) begin
      m_acc = nacc;
      m_idx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_bytes", out_bytes, 3'd0);
    check("rst_level", level, 4'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, '0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_word_bytes(input logic r);
    for (int j = 0; j < 4; j++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, r);
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic f; logic r;
    logic ev; logic [31:0] edata; logic [2:0] eb; logic [3:0] elev;
  } vec_t;

  function automatic vec_t mk(logic v, logic [7:0] d, logic f, logic ev,
                              logic [31:0] edata, logic [2:0] eb, logic [3:0] elev);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.r = 1'b1;
    t.ev = ev; t.edata = edata; t.eb = eb; t.elev = elev;
    return t;
  endfunction

  initial begin
    vec_t tbl[20];
    // Inputs for this cycle, then outputs sampled in the same cycle before the edge.
    tbl[0]  = mk(1, 8'h11, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[1]  = mk(1, 8'h22, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[2]  = mk(1, 8'h33, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[3]  = mk(1, 8'h44, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[4]  = mk(0, 8'h00, 0, 1, 32'h44332211, 3'd4, 4'd1);
    tbl[5]  = mk(0, 8'h00, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[6]  = mk(1, 8'hAA, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[7]  = mk(1, 8'hBB, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[8]  = mk(0, 8'h00, 1, 0, 32'h0, 3'd0, 4'd0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 32'h0000BBAA, 3'd2, 4'd1);
    tbl[10] = mk(1, 8'h01, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[11] = mk(1, 8'h02, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[12] = mk(1, 8'h03, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[13] = mk(1, 8'h04, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[14] = mk(0, 8'h00, 0, 1, 32'h04030201, 3'd4, 4'd1);
    tbl[15] = mk(0, 8'h00, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[16] = mk(1, 8'hCC, 1, 0, 32'h0, 3'd0, 4'd0);
    tbl[17] = mk(0, 8'h00, 1, 1, 32'h000000CC, 3'd1, 4'd1);
    tbl[18] = mk(0, 8'h00, 0, 0, 32'h0, 3'd0, 4'd0);
    tbl[19] = mk(0, 8'h00, 0, 0, 32'h0, 3'd0, 4'd0);

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
    model_clear();
    do_reset();

    // Directed vectors: full word, flushed partial word, flush with a byte, flush at idx 0.
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].r);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].edata);
      check($sformatf("tbl%0d_bytes", i), out_bytes, tbl[i].eb);
      check($sformatf("tbl%0d_level", i), level, tbl[i].elev);
    end

    // Overflow: nine words with the output stalled; the ninth is dropped.
    for (int w = 0; w < 9; w++) push_word_bytes(1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("full_level", level, 4'd8);
    check("full_drop_cnt", drop_cnt, 16'd1);
    check("full_overflow", overflow, 1'b1);
    for (int w = 0; w < 8; w++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("drained_level", level, 4'd0);
    check("sticky_overflow", overflow, 1'b1);

    // Full FIFO, with the completing byte coinciding with a pop, produces no drop.
    for (int w = 0; w < 8; w++) push_word_bytes(1'b0);
    for (int j = 0; j < 3; j++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("coincide_level", level, 4'd8);
    check("coincide_drop_cnt", drop_cnt, 16'd1);
    for (int w = 0; w < 8; w++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // A reset in the middle of a word discards the partial bytes.
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    cycle(1'b1, 8'h66, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 8'h04, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("post_rst_data", out_data, 32'h04030201);
    check("post_rst_bytes", out_bytes, 3'd4);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("final_level", level, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
